uart_param: RTL

- Parametrised successor UART core: run-time baud divider, compile-time data width, optional parity, 1 or 2 stop bits.
- Per-character error flags for the RX path.
- Sits between a CPU/peripheral bus (strobe interface) and the serial pins; one instance per serial channel.
- RX storage is a single-entry buffer, or a small FIFO when the optional feature is compiled in.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_param.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_param core.
//   uart_state_e : state encoding used by both the TX and RX FSMs
//   RxFlagBits   : per-character flag bits stored next to the data (frame, parity)
//   rx_entry_w() : width of one RX storage entry for a given data width
//   par_bit()    : parity bit generator (even when odd = 0, odd when odd = 1)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Widest legal character; narrower data is zero-extended, which leaves XOR parity unchanged.
  localparam int unsigned MaxDataBits = 8;
  localparam int unsigned RxFlagBits  = 2;

  function automatic int unsigned rx_entry_w(input int unsigned data_bits);
    return data_bits + RxFlagBits;
  endfunction

  function automatic logic par_bit(input logic [MaxDataBits-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received characters.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full unless a pop happens in the same cycle)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy status
//   head       : oldest entry
module uart_rx_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[PtrW-1:0]] <= push_data;
        wptr_q <= wptr_q + PtrOne;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised UART core, one instance per serial channel.
// TX serialises d on wr; RX deserialises rxd into storage with frame/parity error flags.
// Optional feature macro UART_RXFIFO_EN: RX storage becomes an RXFIFO_DEPTH-entry FIFO
// (uart_rx_fifo); otherwise it is a single holding register.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   div              : bit period in clk cycles (>= 4)
//   nstop            : 1 = two TX stop bits
//   par_en, par_odd  : parity present / odd parity
//   d, wr, txrdy     : TX data, write strobe, TX idle
//   rd               : pop RX head, clear rxoverr
//   q, rxvalid       : RX head data, storage non-empty
//   rxoverr          : sticky overrun
//   rxframeer/rxparer: head entry stop-bit error / parity error
//   rxd, txd         : serial pins
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned DIV_BITS     = 16,
  parameter int unsigned RXFIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_BITS-1:0]  div,
  input  logic                 nstop,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic [DATA_BITS-1:0] d,
  input  logic                 wr,
  output logic                 txrdy,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] q,
  output logic                 rxvalid,
  output logic                 rxoverr,
  output logic                 rxframeer,
  output logic                 rxparer,
  input  logic                 rxd,
  output logic                 txd
);

  localparam int unsigned         EntryW  = rx_entry_w(DATA_BITS);
  localparam logic [DIV_BITS-1:0] DivOne  = 1;
  localparam logic [3:0]          BitLast = 4'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  uart_state_e            tx_state_q, tx_state_d;
  logic [DIV_BITS-1:0]    tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_stop_q, tx_stop_d, tx_nstop_q, tx_nstop_d;
  logic                   tx_paren_q, tx_paren_d, tx_par_q, tx_par_d;
  logic                   txd_q, txd_d, tx_done;

  assign tx_done = (tx_cnt_q == tx_div_q - DivOne);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_stop_d  = tx_stop_q;
    tx_nstop_d = tx_nstop_q;
    tx_paren_d = tx_paren_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q != StIdle) begin
      tx_cnt_d = tx_done ? '0 : tx_cnt_q + DivOne;
    end
    unique case (tx_state_q)
      StIdle: begin
        if (wr) begin
          // Frame configuration is frozen here for the whole character.
          tx_state_d = StStart;
          tx_cnt_d   = '0;
          tx_div_d   = div;
          tx_shift_d = d;
          tx_nstop_d = nstop;
          tx_paren_d = par_en;
          tx_par_d   = par_bit(MaxDataBits'(d), par_odd);
        end
      end
      StStart: begin
        if (tx_done) begin
          tx_state_d = StData;
          tx_bit_d   = '0;
        end
      end
      StData: begin
        if (tx_done) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BitLast) begin
            tx_state_d = tx_paren_q ? StParity : StStop;
            tx_stop_d  = 1'b0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (tx_done) begin
          tx_state_d = StStop;
          tx_stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (tx_done) begin
          if (tx_stop_q == tx_nstop_q) tx_state_d = StIdle;
          else                         tx_stop_d  = 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase

    // txd is registered from the next state so the pin is glitch-free.
    unique case (tx_state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = tx_shift_d[0];
      StParity: txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_stop_q  <= 1'b0;
      tx_nstop_q <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_stop_q  <= tx_stop_d;
      tx_nstop_q <= tx_nstop_d;
      tx_paren_q <= tx_paren_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign txd   = txd_q;
  assign txrdy = (tx_state_q == StIdle);

  // ---------------------------------------------------------------- RX
  uart_state_e            rx_state_q, rx_state_d;
  logic [DIV_BITS-1:0]    rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_paren_q, rx_paren_d, rx_parodd_q, rx_parodd_d;
  logic                   rx_parbit_q, rx_parbit_d;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic                   rx_edge, rx_fall, rx_samp, rx_push;
  logic [EntryW-1:0]      push_entry;

  assign rx_edge = rx_sync_q ^ rx_prev_q;
  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_samp = (rx_cnt_q == (rx_div_q >> 1) - DivOne);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_paren_d  = rx_paren_q;
    rx_parodd_d = rx_parodd_q;
    rx_parbit_d = rx_parbit_q;
    rx_push     = 1'b0;
    // Resynchronise the bit timer on every line transition.
    if (rx_state_q == StIdle || rx_edge || rx_cnt_q == rx_div_q - DivOne) rx_cnt_d = '0;
    else                                                                   rx_cnt_d = rx_cnt_q + DivOne;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_fall) begin
          rx_state_d  = StStart;
          rx_div_d    = div;
          rx_paren_d  = par_en;
          rx_parodd_d = par_odd;
        end
      end
      StStart: begin
        if (rx_samp) begin
          rx_state_d = rx_sync_q ? StIdle : StData;
          rx_bit_d   = '0;
        end
      end
      StData: begin
        if (rx_samp) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BitLast) rx_state_d = rx_paren_q ? StParity : StStop;
          else                     rx_bit_d   = rx_bit_q + 4'd1;
        end
      end
      StParity: begin
        if (rx_samp) begin
          rx_parbit_d = rx_sync_q;
          rx_state_d  = StStop;
        end
      end
      StStop: begin
        if (rx_samp) begin
          rx_push    = 1'b1;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  assign push_entry = {rx_shift_q, ~rx_sync_q,
                       rx_paren_q & (rx_parbit_q != par_bit(MaxDataBits'(rx_shift_q), rx_parodd_q))};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= StIdle;
      rx_cnt_q    <= '0;
      rx_div_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_paren_q  <= 1'b0;
      rx_parodd_q <= 1'b0;
      rx_parbit_q <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_paren_q  <= rx_paren_d;
      rx_parodd_q <= rx_parodd_d;
      rx_parbit_q <= rx_parbit_d;
    end
  end

  // ---------------------------------------------------------------- RX storage
  logic              st_full, st_empty, rx_overrun, rxoverr_q;
  logic [EntryW-1:0] head;

`ifdef UART_RXFIFO_EN
  uart_rx_fifo #(
    .Width(EntryW),
    .Depth(RXFIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_data(push_entry),
    .pop      (rd),
    .full     (st_full),
    .empty    (st_empty),
    .head     (head)
  );
`else
  logic              hold_valid_q, hold_valid_d;
  logic [EntryW-1:0] hold_q, hold_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (rd) hold_valid_d = 1'b0;
    // A read in the same cycle frees the slot for the incoming character.
    if (rx_push && (!hold_valid_q || rd)) begin
      hold_d       = push_entry;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign st_full  = hold_valid_q;
  assign st_empty = ~hold_valid_q;
  assign head     = hold_q;
`endif

  assign rx_overrun = rx_push & st_full & ~rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxoverr_q <= 1'b0;
    else       rxoverr_q <= rx_overrun | (rxoverr_q & ~rd);
  end

  assign rxvalid   = ~st_empty;
  assign rxoverr   = rxoverr_q;
  assign q         = head[EntryW-1:RxFlagBits];
  assign rxframeer = head[1];
  assign rxparer   = head[0];

endmodule
